// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: writeback vs. buffered long-latency completions,
// plus a pending-register scoreboard for decode hazards. Optional macro: WB_FWD_EN.
module wb_port_arbiter #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            p_valid,
    input  logic [4:0]      p_rd,
    input  logic [XLEN-1:0] p_data,
    output logic            p_ready,
    input  logic            l_issue_valid,
    input  logic [4:0]      l_issue_rd,
    input  logic            l_valid,
    input  logic [4:0]      l_rd,
    input  logic [XLEN-1:0] l_data,
    output logic            l_ready,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    output logic            hazard,
`ifdef WB_FWD_EN
    output logic            fwd1_hit,
    output logic            fwd2_hit,
    output logic [XLEN-1:0] fwd1_data,
    output logic [XLEN-1:0] fwd2_data,
`endif
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [31:0]     pending
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [4:0]      fifo_rd_q   [DEPTH];
    logic [XLEN-1:0] fifo_data_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     pending_q, pending_d;
    logic            rf_we_q, rf_we_d;
    logic [4:0]      rf_waddr_q;
    logic [XLEN-1:0] rf_wdata_q;

    logic            full, enq, drain, grant_p;
    logic [4:0]      win_rd;
    logic [XLEN-1:0] win_data;
    logic            sb_hazard, wb_match1, wb_match2;

    // A full FIFO outranks the pipeline so completions can never be refused forever.
    always_comb begin
        full     = (count_q == DEPTH_C);
        l_ready  = !full;
        enq      = l_valid && !full;
        drain    = full || (!p_valid && count_q != '0);
        grant_p  = p_valid && !full;
        p_ready  = grant_p;
        win_rd   = drain ? fifo_rd_q[rd_ptr_q]   : p_rd;
        win_data = drain ? fifo_data_q[rd_ptr_q] : p_data;
        rf_we_d  = (drain || grant_p) && (win_rd != 5'd0);
        count_d  = count_q + CW'(enq) - CW'(drain);
    end

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        pending_d = pending_q;
        if (drain)
            pending_d[win_rd] = 1'b0;
        if (l_issue_valid)
            pending_d[l_issue_rd] = 1'b1;
        pending_d[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pending_q  <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            count_q   <= count_d;
            pending_q <= pending_d;
            rf_we_q   <= rf_we_d;
            if (enq)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (drain)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            if (rf_we_d) begin
                rf_waddr_q <= win_rd;
                rf_wdata_q <= win_data;
            end
        end
    end

    // NOTE: the FIFO storage has no reset; count_q alone says which entries are valid.
    always_ff @(posedge i_clk) begin
        if (enq) begin
            fifo_rd_q[wr_ptr_q]   <= l_rd;
            fifo_data_q[wr_ptr_q] <= l_data;
        end
    end

    // The regfile has no write-through, so a source matching the in-flight write must see it.
    always_comb begin
        sb_hazard = pending_q[id_rs1] | pending_q[id_rs2] | pending_q[id_rd];
        wb_match1 = rf_we_q && (rf_waddr_q != 5'd0) && (rf_waddr_q == id_rs1);
        wb_match2 = rf_we_q && (rf_waddr_q != 5'd0) && (rf_waddr_q == id_rs2);
`ifdef WB_FWD_EN
        fwd1_hit  = wb_match1;
        fwd2_hit  = wb_match2;
        fwd1_data = rf_wdata_q;
        fwd2_data = rf_wdata_q;
        hazard    = sb_hazard;
`else
        hazard    = sb_hazard | wb_match1 | wb_match2;
`endif
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign pending  = pending_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_wb_port_arbiter;

    localparam int DEPTH = 2;
    localparam int XLEN  = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            p_valid, l_issue_valid, l_valid;
    logic [4:0]      p_rd, l_issue_rd, l_rd, id_rs1, id_rs2, id_rd;
    logic [XLEN-1:0] p_data, l_data;
    logic            p_ready, l_ready, hazard, rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic [31:0]     pending;
`ifdef WB_FWD_EN
    logic            fwd1_hit, fwd2_hit;
    logic [XLEN-1:0] fwd1_data, fwd2_data;
`endif

    int checks = 0;
    int errors = 0;

    wb_port_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .i_clk(clk), .i_rst(rst_n),
        .p_valid(p_valid), .p_rd(p_rd), .p_data(p_data), .p_ready(p_ready),
        .l_issue_valid(l_issue_valid), .l_issue_rd(l_issue_rd),
        .l_valid(l_valid), .l_rd(l_rd), .l_data(l_data), .l_ready(l_ready),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .hazard(hazard),
`ifdef WB_FWD_EN
        .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
        .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
`endif
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pending(pending)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: the late-completion FIFO is a queue, the scoreboard a bit array.
    logic [4:0]      mq_rd[$];
    logic [XLEN-1:0] mq_data[$];
    bit              m_pend[32];
    logic            m_we;
    logic [4:0]      m_waddr;
    logic [XLEN-1:0] m_wdata;
    logic            e_p_ready, e_l_ready, e_hazard, e_drain, e_pipe;

    function automatic logic [31:0] m_pend_vec();
        logic [31:0] v = '0;
        for (int i = 0; i < 32; i++) v[i] = m_pend[i];
        return v;
    endfunction

    function automatic void model_reset();
        mq_rd.delete();
        mq_data.delete();
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        m_we    = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
    endfunction

    function automatic void model_comb();
        int n = mq_rd.size();
        logic regw_stall;
        e_l_ready = (n < DEPTH);
        e_drain   = (n == DEPTH) || (!p_valid && n > 0);
        e_pipe    = (n < DEPTH) && p_valid;
        e_p_ready = e_pipe;
        regw_stall = m_we && m_waddr != 0 && (m_waddr == id_rs1 || m_waddr == id_rs2);
        e_hazard  = m_pend[id_rs1] || m_pend[id_rs2] || m_pend[id_rd];
`ifndef WB_FWD_EN
        e_hazard  = e_hazard || regw_stall;
`endif
    endfunction

    // Advance one clock and apply the cycle's rules to the model.
    task automatic tick();
        logic [4:0]      r;
        logic [XLEN-1:0] d;
        model_comb();
        @(posedge clk);
        m_we = 1'b0;
        if (e_drain) begin
            r = mq_rd.pop_front();
            d = mq_data.pop_front();
            m_pend[r] = 1'b0;
        end else begin
            r = p_rd;
            d = p_data;
        end
        if ((e_drain || e_pipe) && r != 0) begin
            m_we    = 1'b1;
            m_waddr = r;
            m_wdata = d;
        end
        if (l_valid && e_l_ready) begin
            mq_rd.push_back(l_rd);
            mq_data.push_back(l_data);
        end
        if (l_issue_valid) m_pend[l_issue_rd] = 1'b1;
        m_pend[0] = 1'b0;
        #1;
    endtask

    task automatic idle_inputs();
        p_valid = 0; p_rd = 0; p_data = 0;
        l_issue_valid = 0; l_issue_rd = 0;
        l_valid = 0; l_rd = 0; l_data = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we: got %b want 0", rf_we); end
        checks++; if (rf_waddr !== 5'd0) begin errors++; $display("FAIL reset_rf_waddr: got %0d want 0", rf_waddr); end
        checks++; if (rf_wdata !== '0) begin errors++; $display("FAIL reset_rf_wdata: got %h want 0", rf_wdata); end
        checks++; if (pending !== 32'd0) begin errors++; $display("FAIL reset_pending: got %h want 0", pending); end
        checks++; if (l_ready !== 1'b1) begin errors++; $display("FAIL reset_l_ready: got %b want 1", l_ready); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_pipeline_write();
        idle_inputs();
        p_valid = 1; p_rd = 5'd3; p_data = 32'hDEADBEEF;
        #1;
        checks++; if (p_ready !== 1'b1) begin errors++; $display("FAIL pipe_p_ready: got %b want 1", p_ready); end
        tick();
        checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL pipe_rf_we: got %b want 1", rf_we); end
        checks++; if (rf_waddr !== 5'd3) begin errors++; $display("FAIL pipe_rf_waddr: got %0d want 3", rf_waddr); end
        checks++; if (rf_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL pipe_rf_wdata: got %h want deadbeef", rf_wdata); end
        idle_inputs();
        tick();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL pipe_idle_we: got %b want 0", rf_we); end
    endtask

    task automatic test_late_completion();
        idle_inputs();
        l_issue_valid = 1; l_issue_rd = 5'd7;
        tick();
        l_issue_valid = 0;
        checks++; if (pending[7] !== 1'b1) begin errors++; $display("FAIL late_pending_set: got %b want 1", pending[7]); end
        for (int i = 0; i < 4; i++) begin
            p_valid = 1; p_rd = 5'(20 + i); p_data = 32'h1000 + i;
            l_valid = (i == 0); l_rd = 5'd7; l_data = 32'h11;
            #1;
            checks++; if (p_ready !== 1'b1) begin errors++; $display("FAIL late_p_ready[%0d]: got %b want 1", i, p_ready); end
            tick();
            checks++; if (rf_waddr !== 5'(20 + i)) begin errors++; $display("FAIL late_pipe_addr[%0d]: got %0d want %0d", i, rf_waddr, 20 + i); end
            checks++; if (pending[7] !== 1'b1) begin errors++; $display("FAIL late_pending_held[%0d]: got %b want 1", i, pending[7]); end
        end
        idle_inputs();
        tick();
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h11)
            begin errors++; $display("FAIL late_drain: got we=%b addr=%0d data=%h want we=1 addr=7 data=11", rf_we, rf_waddr, rf_wdata); end
        checks++; if (pending[7] !== 1'b0) begin errors++; $display("FAIL late_pending_clear: got %b want 0", pending[7]); end
    endtask

    task automatic test_fifo_full();
        idle_inputs();
        l_issue_valid = 1; l_issue_rd = 5'd8; tick();
        l_issue_rd = 5'd9; tick();
        l_issue_valid = 0;
        p_valid = 1; p_rd = 5'd1; p_data = 32'hA1;
        l_valid = 1; l_rd = 5'd8; l_data = 32'h88; tick();
        l_rd = 5'd9; l_data = 32'h99; tick();
        l_valid = 0;
        p_rd = 5'd2; p_data = 32'hA2;
        #1;
        checks++; if (p_ready !== 1'b0) begin errors++; $display("FAIL full_p_ready: got %b want 0", p_ready); end
        checks++; if (l_ready !== 1'b0) begin errors++; $display("FAIL full_l_ready: got %b want 0", l_ready); end
        tick();
        checks++; if (rf_waddr !== 5'd8 || rf_wdata !== 32'h88)
            begin errors++; $display("FAIL full_first_drain: got addr=%0d data=%h want 8/88", rf_waddr, rf_wdata); end
        checks++; if (p_ready !== 1'b1) begin errors++; $display("FAIL full_resume: got %b want 1", p_ready); end
        tick();
        checks++; if (rf_waddr !== 5'd2) begin errors++; $display("FAIL full_pipe_after: got %0d want 2", rf_waddr); end
        idle_inputs();
        tick();
        checks++; if (rf_waddr !== 5'd9 || rf_wdata !== 32'h99)
            begin errors++; $display("FAIL full_second_drain: got addr=%0d data=%h want 9/99", rf_waddr, rf_wdata); end
        checks++; if (pending[9:8] !== 2'b00) begin errors++; $display("FAIL full_pending: got %b want 00", pending[9:8]); end
    endtask

    task automatic test_hazard();
        idle_inputs();
        l_issue_valid = 1; l_issue_rd = 5'd10; tick();
        l_issue_valid = 0;
        id_rs2 = 5'd10; #1;
        checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL haz_rs2: got %b want 1", hazard); end
        id_rs2 = 0; id_rd = 5'd10; #1;
        checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL haz_waw: got %b want 1", hazard); end
        id_rd = 0;
        l_issue_valid = 1; l_issue_rd = 5'd0; tick();
        l_issue_valid = 0; id_rs1 = 0; #1;
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL haz_x0: got %b want 0", hazard); end
        checks++; if (pending[0] !== 1'b0) begin errors++; $display("FAIL haz_pending0: got %b want 0", pending[0]); end
        // Retire x10 so it does not linger in later scenarios.
        l_valid = 1; l_rd = 5'd10; l_data = 32'h10; tick();
        idle_inputs(); tick();
        checks++; if (pending[10] !== 1'b0) begin errors++; $display("FAIL haz_clear10: got %b want 0", pending[10]); end
    endtask

    task automatic test_set_wins();
        idle_inputs();
        l_issue_valid = 1; l_issue_rd = 5'd12; tick();
        l_issue_valid = 0;
        l_valid = 1; l_rd = 5'd12; l_data = 32'hC12; tick();
        l_valid = 0;
        l_issue_valid = 1; l_issue_rd = 5'd12; tick();
        checks++; if (rf_waddr !== 5'd12 || rf_we !== 1'b1) begin errors++; $display("FAIL setwins_drain: got we=%b addr=%0d want 1/12", rf_we, rf_waddr); end
        checks++; if (pending[12] !== 1'b1) begin errors++; $display("FAIL setwins_pending: got %b want 1", pending[12]); end
        idle_inputs();
        l_valid = 1; l_rd = 5'd12; l_data = 32'hC13; tick();
        idle_inputs(); tick();
    endtask

    task automatic test_forward();
        idle_inputs();
        p_valid = 1; p_rd = 5'd4; p_data = 32'h4444_0004; tick();
        idle_inputs();
        id_rs1 = 5'd4; #1;
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd4) begin errors++; $display("FAIL fwd_setup: got we=%b addr=%0d want 1/4", rf_we, rf_waddr); end
`ifdef WB_FWD_EN
        checks++; if (fwd1_hit !== 1'b1) begin errors++; $display("FAIL fwd1_hit: got %b want 1", fwd1_hit); end
        checks++; if (fwd1_data !== 32'h4444_0004) begin errors++; $display("FAIL fwd1_data: got %h want 44440004", fwd1_data); end
        checks++; if (fwd2_hit !== 1'b0) begin errors++; $display("FAIL fwd2_hit: got %b want 0", fwd2_hit); end
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL fwd_hazard: got %b want 0", hazard); end
`else
        checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL fwd_rs1_stall: got %b want 1", hazard); end
        id_rs1 = 0; id_rs2 = 5'd4; #1;
        checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL fwd_rs2_stall: got %b want 1", hazard); end
        id_rs2 = 0; id_rd = 5'd4; #1;
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL fwd_rd_nostall: got %b want 0", hazard); end
`endif
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            p_valid       = ($urandom_range(0, 99) < 55);
            p_rd          = 5'($urandom_range(0, 15));
            p_data        = $urandom;
            l_issue_valid = ($urandom_range(0, 99) < 25);
            l_issue_rd    = 5'($urandom_range(0, 15));
            l_valid       = ($urandom_range(0, 99) < 40);
            l_rd          = 5'($urandom_range(0, 15));
            l_data        = $urandom;
            id_rs1        = 5'($urandom_range(0, 15));
            id_rs2        = 5'($urandom_range(0, 15));
            id_rd         = 5'($urandom_range(0, 15));
            #1;
            model_comb();
            checks++; if (p_ready !== e_p_ready) begin errors++; $display("FAIL rnd_p_ready[%0d]: got %b want %b", c, p_ready, e_p_ready); end
            checks++; if (l_ready !== e_l_ready) begin errors++; $display("FAIL rnd_l_ready[%0d]: got %b want %b", c, l_ready, e_l_ready); end
            checks++; if (hazard !== e_hazard) begin errors++; $display("FAIL rnd_hazard[%0d]: got %b want %b", c, hazard, e_hazard); end
            tick();
            checks++; if (rf_we !== m_we) begin errors++; $display("FAIL rnd_rf_we[%0d]: got %b want %b", c, rf_we, m_we); end
            if (m_we) begin
                checks++; if (rf_waddr !== m_waddr || rf_wdata !== m_wdata)
                    begin errors++; $display("FAIL rnd_rf_write[%0d]: got %0d/%h want %0d/%h", c, rf_waddr, rf_wdata, m_waddr, m_wdata); end
            end
            checks++; if (pending !== m_pend_vec()) begin errors++; $display("FAIL rnd_pending[%0d]: got %h want %h", c, pending, m_pend_vec()); end
        end
    endtask

    task automatic test_reset_midstream();
        idle_inputs();
        l_issue_valid = 1; l_issue_rd = 5'd5; tick();
        l_issue_valid = 0;
        p_valid = 1; p_rd = 5'd6; p_data = 32'h66;
        l_valid = 1; l_rd = 5'd5; l_data = 32'h55; tick();
        idle_inputs();
        checks++; if (pending[5] !== 1'b1 || rf_we !== 1'b1) begin errors++; $display("FAIL mid_setup: got pend5=%b we=%b want 1/1", pending[5], rf_we); end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++; if (pending !== 32'd0) begin errors++; $display("FAIL mid_pending: got %h want 0", pending); end
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL mid_rf_we: got %b want 0", rf_we); end
        checks++; if (l_ready !== 1'b1) begin errors++; $display("FAIL mid_l_ready: got %b want 1", l_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL mid_fifo_empty: got %b want 0", rf_we); end
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b1;
        #2;
        test_reset();
        test_pipeline_write();
        test_late_completion();
        test_fifo_full();
        test_hazard();
        test_set_wins();
        test_forward();
        test_random();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
